// File: rtl/mmm_ctrl.sv
// Word-serial Montgomery multiplier controller: sequences one external PE
//   through N*E beats and produces Z = X*Y*2^-N mod M.
// Latency: start accepted at edge k -> done in the cycle after edge k+N*E+3.
//   An even modulus aborts with done in the cycle after edge k+2.
// Backpressure: none; start is only sampled in IDLE and is dropped otherwise.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, x_in, y_in, m_in  request and operands (captured on acceptance)
//   busy, done, err, z_out   status, completion pulse, even-M flag, result
//   pe_enable .. pe_S1_old   beat strobe and per-beat operands to the PE
//   pe_S0_new, pe_cout       registered PE results (valid one cycle after a beat)
module mmm_ctrl #(
    parameter int N = 6,
    parameter int W = 3,
    parameter int E = (N + W) / W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    input  logic [N-1:0] m_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] z_out,
    output logic         pe_enable,
    output logic         pe_xi,
    output logic         pe_c,
    output logic [W-1:0] pe_Yj,
    output logic [W-1:0] pe_Mj,
    output logic [1:0]   pe_cin,
    output logic [W-1:0] pe_S0_old,
    output logic [W-1:0] pe_S1_old,
    input  logic [W-1:0] pe_S0_new,
    input  logic [1:0]   pe_cout
);

    localparam int EW = E * W;
    localparam int IW = $clog2(N);
    localparam int JW = $clog2(E);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_FINAL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;

    logic [N-1:0]   x_q;
    logic [W-1:0]   y_w_q [E];
    logic [W-1:0]   m_w_q [E];
    logic [W-1:0]   s_q   [E];
    logic [IW-1:0]  i_q;
    logic [JW-1:0]  j_q;
    logic           c_q;
    logic           err_q;
    logic [N-1:0]   z_q;
    logic           wb_vld_q;
    logic [JW-1:0]  wb_idx_q;

    logic           accept;
    logic           j_first;
    logic           j_last;
    logic           i_last;
    logic [JW-1:0]  j_nxt;
    logic [W-1:0]   s_cur;
    logic [W-1:0]   s_nxt;
    logic [W-1:0]   s_w0;
    logic           c_new;
    logic [EW-1:0]  y_ext;
    logic [EW-1:0]  m_ext;
    logic [EW-1:0]  r_cat;
    logic [EW-1:0]  m_cat;
    logic [EW-1:0]  r_fin;

    assign accept  = (state_q == S_IDLE) && start;
    assign j_first = (j_q == '0);
    assign j_last  = (j_q == JW'(E - 1));
    assign i_last  = (i_q == IW'(N - 1));
    // Saturate so the neighbour index never leaves the word array.
    assign j_nxt   = j_last ? j_q : j_q + JW'(1);

    assign y_ext = {{(EW - N){1'b0}}, y_in};
    assign m_ext = {{(EW - N){1'b0}}, m_in};

    // Partial-sum reads. A word written back this very cycle is forwarded
    // from the PE so a read never sees the stale copy; with E=2 the beat
    // at j=0 reads S[1] in the same cycle its writeback lands.
    always_comb begin
        s_cur = s_q[j_q];
        if (wb_vld_q && (wb_idx_q == j_q)) begin
            s_cur = pe_S0_new;
        end
        s_nxt = s_q[j_nxt];
        if (wb_vld_q && (wb_idx_q == j_nxt)) begin
            s_nxt = pe_S0_new;
        end
        if (j_last) begin
            s_nxt = '0;
        end
        s_w0 = s_q[0];
        if (wb_vld_q && (wb_idx_q == '0)) begin
            s_w0 = pe_S0_new;
        end
    end

    // Quotient bit: chooses whether M is added so the running sum is even.
    assign c_new = s_w0[0] ^ (x_q[i_q] & y_w_q[0][0]);

    // Final reduction of the E-word sum into [0, M).
    always_comb begin
        r_cat = '0;
        m_cat = '0;
        for (int k = 0; k < E; k++) begin
            r_cat[k*W +: W] = s_q[k];
            m_cat[k*W +: W] = m_w_q[k];
        end
        r_fin = (r_cat >= m_cat) ? (r_cat - m_cat) : r_cat;
    end

    // Next state and PE beat outputs.
    always_comb begin
        state_d   = state_q;
        pe_enable = 1'b0;
        pe_xi     = 1'b0;
        pe_c      = 1'b0;
        pe_Yj     = '0;
        pe_Mj     = '0;
        pe_cin    = 2'b00;
        pe_S0_old = '0;
        pe_S1_old = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // An even modulus has no inverse of 2; skip straight to the
                // result stage, which reports zero with err.
                state_d = m_w_q[0][0] ? S_RUN : S_FINAL;
            end
            S_RUN: begin
                pe_enable = 1'b1;
                pe_xi     = x_q[i_q];
                pe_c      = j_first ? c_new : c_q;
                pe_Yj     = y_w_q[j_q];
                pe_Mj     = m_w_q[j_q];
                pe_cin    = j_first ? 2'b00 : pe_cout;
                pe_S0_old = s_cur;
                pe_S1_old = s_nxt;
                if (i_last && j_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_FINAL;
            S_FINAL: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            c_q      <= 1'b0;
            err_q    <= 1'b0;
            z_q      <= '0;
            wb_vld_q <= 1'b0;
            wb_idx_q <= '0;
            for (int k = 0; k < E; k++) begin
                y_w_q[k] <= '0;
                m_w_q[k] <= '0;
                s_q[k]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            // Each beat's PE result arrives one cycle later; remember where
            // it goes.
            wb_vld_q <= (state_q == S_RUN);
            wb_idx_q <= j_q;

            if (accept) begin
                x_q   <= x_in;
                i_q   <= '0;
                j_q   <= '0;
                err_q <= 1'b0;
                for (int k = 0; k < E; k++) begin
                    y_w_q[k] <= y_ext[k*W +: W];
                    m_w_q[k] <= m_ext[k*W +: W];
                    s_q[k]   <= '0;
                end
            end else if (wb_vld_q) begin
                s_q[wb_idx_q] <= pe_S0_new;
            end

            if (state_q == S_LOAD) begin
                err_q <= ~m_w_q[0][0];
            end

            if (state_q == S_RUN) begin
                if (j_first) begin
                    c_q <= c_new;
                end
                if (j_last) begin
                    j_q <= '0;
                    i_q <= i_q + IW'(1);
                end else begin
                    j_q <= j_q + JW'(1);
                end
            end

            if (state_q == S_FINAL) begin
                z_q <= err_q ? '0 : N'(r_fin);
            end
        end
    end

    assign busy  = (state_q == S_LOAD) || (state_q == S_RUN) ||
                   (state_q == S_DRAIN) || (state_q == S_FINAL);
    assign done  = (state_q == S_DONE);
    assign err   = done && err_q;
    assign z_out = z_q;

endmodule
